// File: rtl/picorv32_native_mem_if.sv
// PicoRV32 native memory bus: the core drives a request, and the memory
// answers with a one-cycle mem_ready pulse that carries mem_rdata.
interface picorv32_native_mem_if;
    logic        mem_valid;
    logic        mem_instr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;

    modport master (
        output mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        input  mem_ready, mem_rdata
    );

    modport slave (
        input  mem_valid, mem_instr, mem_addr, mem_wdata, mem_wstrb,
        output mem_ready, mem_rdata
    );
endinterface

// File: rtl/picorv32_native_mem.sv
// Native-interface memory slave for PicoRV32 benches. It provides a
// word-addressed RAM with byte strobes, programmable read and write wait
// states, and a tohost completion register. It also has a backdoor loader
// and saturating fetch and write counters.
module picorv32_native_mem #(
    parameter int unsigned MEM_WORDS     = 8192,
    parameter int unsigned READ_LATENCY  = 1,
    parameter int unsigned WRITE_LATENCY = 1,
    parameter logic [31:0] TOHOST_ADDR   = 32'h1000_0000
) (
    input  logic                         clk,
    input  logic                         resetn,
    picorv32_native_mem_if.slave         bus,
    input  logic                         ld_en,
    input  logic [$clog2(MEM_WORDS)-1:0] ld_addr,
    input  logic [31:0]                  ld_data,
    output logic                         done,
    output logic                         pass,
    output logic [31:0]                  tohost_val,
    output logic                         err_oob,
    output logic [31:0]                  fetch_count,
    output logic [31:0]                  write_count
);
    localparam int         AW         = $clog2(MEM_WORDS);
    localparam logic [3:0] READ_WAIT  = 4'(READ_LATENCY - 1);
    localparam logic [3:0] WRITE_WAIT = 4'(WRITE_LATENCY - 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t      state;
    logic [3:0]  wait_cnt;
    logic [29:0] req_word;
    logic [31:0] req_wdata;
    logic [3:0]  req_wstrb;
    logic        req_instr;

    logic [31:0] ram [MEM_WORDS];

    logic        accept;
    logic        commit;
    logic [3:0]  load_cnt;
    logic [29:0] c_word;
    logic [31:0] c_wdata;
    logic [3:0]  c_wstrb;
    logic        c_instr;
    logic        c_is_tohost;
    logic        c_in_ram;
    logic [AW-1:0] c_idx;

    // Byte-offset bits are ignored by the word-addressed decode.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus.mem_addr[1:0];

    // Select the fields that commit on this edge and decode their target.
    // With a zero wait count, the commit happens on the accepting edge, so it
    // uses the live bus. Otherwise it uses the fields latched at acceptance.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        c_word  = req_word;
        c_wdata = req_wdata;
        c_wstrb = req_wstrb;
        c_instr = req_instr;
        if (state == IDLE) begin
            c_word  = bus.mem_addr[31:2];
            c_wdata = bus.mem_wdata;
            c_wstrb = bus.mem_wstrb;
            c_instr = bus.mem_instr;
        end
        accept   = (state == IDLE) && bus.mem_valid && !ld_en;
        load_cnt = (bus.mem_wstrb == 4'b0000) ? READ_WAIT : WRITE_WAIT;
        // A counter value of 1 in WAIT means it reaches 0 on this edge.
        commit   = resetn && ((accept && load_cnt == 4'd0) ||
                              (state == WAIT && wait_cnt == 4'd1));
        c_is_tohost = (c_word == TOHOST_ADDR[31:2]);
        c_in_ram    = !c_is_tohost && (c_word[29:AW] == '0);
        c_idx       = c_word[AW-1:0];
    end

    // Handshake FSM, completion register, error flag and activity counters.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state         <= IDLE;
            wait_cnt      <= 4'd0;
            req_word      <= '0;
            req_wdata     <= '0;
            req_wstrb     <= '0;
            req_instr     <= 1'b0;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
            done          <= 1'b0;
            pass          <= 1'b0;
            tohost_val    <= '0;
            err_oob       <= 1'b0;
            fetch_count   <= '0;
            write_count   <= '0;
        end else begin
            // NOTE: state registers use non-blocking assignment only, so every
            // read in this block sees the value from before the edge.
            bus.mem_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        req_word  <= bus.mem_addr[31:2];
                        req_wdata <= bus.mem_wdata;
                        req_wstrb <= bus.mem_wstrb;
                        req_instr <= bus.mem_instr;
                        wait_cnt  <= load_cnt;
                        state     <= (load_cnt == 4'd0) ? RESP : WAIT;
                    end
                end
                WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= RESP;
                end
                RESP: state <= IDLE;
                default: state <= IDLE;
            endcase

            if (commit) begin
                bus.mem_ready <= 1'b1;
                if (c_wstrb == 4'b0000) begin
                    if (c_is_tohost) begin
                        bus.mem_rdata <= tohost_val;
                    end else if (c_in_ram) begin
                        bus.mem_rdata <= ram[c_idx];
                    end else begin
                        bus.mem_rdata <= '0;
                        err_oob       <= 1'b1;
                    end
                    if (c_instr && fetch_count != 32'hFFFF_FFFF)
                        fetch_count <= fetch_count + 32'd1;
                end else begin
                    if (c_is_tohost) begin
                        done       <= 1'b1;
                        pass       <= (c_wdata == 32'h1);
                        tohost_val <= c_wdata;
                    end else if (!c_in_ram) begin
                        err_oob <= 1'b1;
                    end
                    if (write_count != 32'hFFFF_FFFF)
                        write_count <= write_count + 32'd1;
                end
            end
        end
    end

    // RAM write port: core byte-strobe writes, then the loader (loader wins).
    always_ff @(posedge clk) begin
        // NOTE: the RAM has no reset; its contents survive resetn and the
        // loader is honoured even while resetn is low.
        if (commit && c_in_ram && c_wstrb != 4'b0000) begin
            for (int b = 0; b < 4; b++) begin
                if (c_wstrb[b]) ram[c_idx][8*b +: 8] <= c_wdata[8*b +: 8];
            end
        end
        if (ld_en) ram[ld_addr] <= ld_data;
    end
endmodule
